csa_seq_adder_ctrl: RTL and testbench



---
 rtl/csa_pkg.sv | 18 +
 rtl/carry_select_adder.sv | 22 ++
 rtl/csa_seq_adder_ctrl.sv | 117 +++++++++++
 tb/tb_csa_seq_adder_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the sequential carry-select adder controller:
// FSM encoding, slice width and the pass-count helper.
package csa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of slice passes needed to cover a WIDTH-bit operand.
    function automatic int calc_passes(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/carry_select_adder.sv
// Existing 4-bit carry-select adder slice: the low half ripples, the high half
// is precomputed for both carry values and selected by the low-half carry.
module carry_select_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] S,
    output logic       cout
);

    logic [2:0] lo;
    logic [2:0] hi_c0;
    logic [2:0] hi_c1;

    assign lo    = {1'b0, A[1:0]} + {1'b0, B[1:0]} + {2'b00, cin};
    assign hi_c0 = {1'b0, A[3:2]} + {1'b0, B[3:2]};
    assign hi_c1 = {1'b0, A[3:2]} + {1'b0, B[3:2]} + 3'd1;

    assign S    = {(lo[2] ? hi_c1[1:0] : hi_c0[1:0]), lo[1:0]};
    assign cout = lo[2] ? hi_c1[2] : hi_c0[2];

endmodule

// File: rtl/csa_seq_adder_ctrl.sv
// WIDTH-bit adder built by running one 4-bit carry_select_adder slice over
// WIDTH/4 cycles, LSB nibble first, with valid/ready on both sides.
module csa_seq_adder_ctrl
    import csa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N     = calc_passes(WIDTH);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
            $error("csa_seq_adder_ctrl: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               c_reg;
    logic [CNT_W-1:0]   cnt;

    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_cout;
    logic [WIDTH-1:0]    sum_shift;
    logic                accept;
    logic                last_pass;

    carry_select_adder u_slice (
        .A    (a_reg[NIBBLE_W-1:0]),
        .B    (b_reg[NIBBLE_W-1:0]),
        .cin  (c_reg),
        .S    (slice_s),
        .cout (slice_cout)
    );

    // New nibble enters at the top so the first pass ends up in the LSBs.
    generate
        if (WIDTH == NIBBLE_W) begin : g_single
            assign sum_shift = slice_s;
        end else begin : g_multi
            assign sum_shift = {slice_s, sum_reg[WIDTH-1:NIBBLE_W]};
        end
    endgenerate

    assign accept    = in_valid && in_ready;
    assign last_pass = (cnt == CNT_W'(N - 1));

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)                  state_next = RUN;
            RUN:     if (last_pass)               state_next = DONE;
            DONE:    if (out_valid && out_ready)  state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
            c_reg   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= a;
                        b_reg <= b;
                        c_reg <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> NIBBLE_W;
                    b_reg   <= b_reg >> NIBBLE_W;
                    sum_reg <= sum_shift;
                    c_reg   <= slice_cout;
                    cnt     <= last_pass ? '0 : cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Handshake flags come straight from the state register; rst only masks them.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE) && !rst;
    assign busy      = ((state == RUN) || (state == DONE)) && !rst;
    assign sum       = sum_reg;
    assign cout      = c_reg;

endmodule

// File: tb/tb_csa_seq_adder_ctrl.sv
// Directed bench for csa_seq_adder_ctrl at WIDTH=16 and WIDTH=4 with
// hand-computed results, latency, backpressure and reset scenarios.
module tb_csa_seq_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
    logic [15:0] a, b, sum;

    logic        in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
    logic [3:0]  a4, b4, sum4;

    int pass_cnt  = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    csa_seq_adder_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    csa_seq_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        in_valid = 1'b1; a = av; b = bv; cin = cv;
        step();
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            step();
            cycles++;
        end
        if (!out_valid) cycles = -1;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 0;
        in_valid4 = 0; a4 = 0; b4 = 0; cin4 = 0; out_ready4 = 0;
        step();
        step();
        check_cnt++;
        if ({in_ready, out_valid, busy} !== 3'b000)
            $display("FAIL reset_flags: got %b expected %b", {in_ready, out_valid, busy}, 3'b000);
        else pass_cnt++;
        check_cnt++;
        if ({cout, sum} !== 17'h00000)
            $display("FAIL reset_result: got %h expected %h", {cout, sum}, 17'h00000);
        else pass_cnt++;
        check_cnt++;
        if (in_ready4 !== 1'b0)
            $display("FAIL reset_in_ready4: got %b expected 0", in_ready4);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        check_cnt++;
        if (in_ready !== 1'b1)
            $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
        else pass_cnt++;
        step();
        check_cnt++;
        if ({in_ready, out_valid, busy, cout, sum} !== 20'h80000)
            $display("FAIL reset_idle: got %h expected %h", {in_ready, out_valid, busy, cout, sum}, 20'h80000);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int cyc;
        start_op(16'h1234, 16'h4321, 1'b0);
        check_cnt++;
        if ({busy, out_valid, in_ready} !== 3'b100)
            $display("FAIL basic_run_flags: got %b expected %b", {busy, out_valid, in_ready}, 3'b100);
        else pass_cnt++;
        wait_done(cyc);
        check_cnt++;
        if (cyc != 4) $display("FAIL basic_latency: got %0d expected 4", cyc);
        else pass_cnt++;
        check_cnt++;
        if ({cout, sum} !== 17'h05555)
            $display("FAIL basic_sum: got %h expected %h", {cout, sum}, 17'h05555);
        else pass_cnt++;
        finish_op();
        check_cnt++;
        if ({in_ready, out_valid, busy} !== 3'b100)
            $display("FAIL basic_return_idle: got %b expected %b", {in_ready, out_valid, busy}, 3'b100);
        else pass_cnt++;
    endtask

    task automatic test_carry();
        int cyc;
        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done(cyc);
        check_cnt++;
        if (cyc != 4) $display("FAIL carry_latency: got %0d expected 4", cyc);
        else pass_cnt++;
        check_cnt++;
        if ({cout, sum} !== 17'h10000)
            $display("FAIL carry_ripple: got %h expected %h", {cout, sum}, 17'h10000);
        else pass_cnt++;
        finish_op();
        start_op(16'h0000, 16'h0000, 1'b1);
        wait_done(cyc);
        check_cnt++;
        if ({cout, sum} !== 17'h00001)
            $display("FAIL carry_in_only: got %h expected %h", {cout, sum}, 17'h00001);
        else pass_cnt++;
        finish_op();
    endtask

    task automatic test_backpressure();
        int cyc;
        bit stable = 1'b1;
        start_op(16'h1234, 16'h4321, 1'b0);
        wait_done(cyc);
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== 17'h05555)
                stable = 1'b0;
        end
        check_cnt++;
        if (!stable || cyc != 4)
            $display("FAIL backpressure_hold: got stable=%b latency=%0d expected stable=1 latency=4", stable, cyc);
        else pass_cnt++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_cnt++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL backpressure_release: got %b expected %b", {in_ready, out_valid}, 2'b10);
        else pass_cnt++;
    endtask

    task automatic test_ignore_in_valid();
        int cyc;
        bit phantom = 1'b0;
        start_op(16'h0F0F, 16'h00F1, 1'b0);
        step();
        in_valid = 1'b1; a = 16'hAAAA; b = 16'hAAAA; cin = 1'b1;
        check_cnt++;
        if (in_ready !== 1'b0)
            $display("FAIL ignore_in_ready: got %b expected 0", in_ready);
        else pass_cnt++;
        step();
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        wait_done(cyc);
        check_cnt++;
        if ({cout, sum} !== 17'h01000 || cyc < 0)
            $display("FAIL ignore_result: got %h expected %h", {cout, sum}, 17'h01000);
        else pass_cnt++;
        finish_op();
        for (int i = 0; i < 6; i++) begin
            if (busy !== 1'b0 || out_valid !== 1'b0) phantom = 1'b1;
            step();
        end
        check_cnt++;
        if (phantom)
            $display("FAIL ignore_no_phantom_op: got busy activity expected idle");
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        int cyc;
        bit seen_valid = 1'b0;
        start_op(16'h1111, 16'h2222, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_cnt++;
        if ({out_valid, busy, cout, sum} !== 19'h00000)
            $display("FAIL midreset_clear: got %h expected %h", {out_valid, busy, cout, sum}, 19'h00000);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        check_cnt++;
        if (seen_valid)
            $display("FAIL midreset_no_valid: got out_valid=1 expected 0");
        else pass_cnt++;
        start_op(16'h8000, 16'h8000, 1'b1);
        wait_done(cyc);
        check_cnt++;
        if (cyc != 4 || {cout, sum} !== 17'h10001)
            $display("FAIL midreset_after: got %h (latency %0d) expected %h (latency 4)", {cout, sum}, cyc, 17'h10001);
        else pass_cnt++;
        finish_op();
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                       output logic [4:0] res, output bit on_time);
        in_valid4 = 1'b1; a4 = av; b4 = bv; cin4 = cv;
        step();
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        on_time = (out_valid4 === 1'b0) && (busy4 === 1'b1);
        step();
        on_time = on_time && (out_valid4 === 1'b1);
        res = {cout4, sum4};
        out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        on_time = on_time && (in_ready4 === 1'b1);
    endtask

    task automatic test_width4();
        logic [4:0] res;
        bit on_time;
        op4(4'd2, 4'd6, 1'b1, res, on_time);
        check_cnt++;
        if (!on_time || res !== 5'h09)
            $display("FAIL w4_2_6_1: got %h on_time=%b expected %h on_time=1", res, on_time, 5'h09);
        else pass_cnt++;
        op4(4'd7, 4'd3, 1'b1, res, on_time);
        check_cnt++;
        if (!on_time || res !== 5'h0B)
            $display("FAIL w4_7_3_1: got %h on_time=%b expected %h on_time=1", res, on_time, 5'h0B);
        else pass_cnt++;
        op4(4'hF, 4'hF, 1'b1, res, on_time);
        check_cnt++;
        if (!on_time || res !== 5'h1F)
            $display("FAIL w4_f_f_1: got %h on_time=%b expected %h on_time=1", res, on_time, 5'h1F);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_ignore_in_valid();
        test_mid_reset();
        test_width4();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
